uart_transmitter: RTL and testbench

- Serial transmit end of the FPGA_SERIAL_TX/FPGA_SERIAL_RX link on Riscv151; the byte-source counterpart of the CPU's UART receive path.
- Accepts bytes from the CPU's memory-mapped I/O over a ready/valid handshake and buffers them in a small FIFO.
- Serializes each byte as 8N1 frames on serial_out, which drives FPGA_SERIAL_TX.
- Lets software issue several stores without polling between bytes, and lets benches observe CPU output on the serial line.

---
 rtl/uart_transmitter.sv | 129 ++++++++++++
 tb/tb_uart_transmitter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// 8N1 serial transmitter fed by a small byte FIFO over valid/ready.
// Back-to-back bytes leave STOP straight into START with no idle gap.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic                        serial_out,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int SET = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = (SET > 1) ? $clog2(SET) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] SYM_LAST = CW'(SET - 1);
  localparam logic [CW-1:0] SYM_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] sym_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          sym_end;
  logic          empty;
  logic          push;
  logic          pop;
  logic          line_n;

  assign empty         = (count == '0);
  assign data_in_ready = (count != FULL);
  assign push          = data_in_valid & data_in_ready;
  assign fifo_count    = count;
  assign tx_busy       = (state != IDLE) | ~empty;
  assign sym_end       = (sym_cnt == SYM_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    line_n  = 1'b1;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        line_n = 1'b0;
        if (sym_end) state_n = DATA;
      end
      DATA: begin
        line_n = shift[bit_idx];
        if (sym_end && bit_idx == 3'd7) state_n = STOP;
      end
      STOP: begin
        if (sym_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line is registered from the current state, so it lags the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sym_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_n;
      serial_out <= line_n;
      if (pop) shift <= mem[rd_ptr];
      if (state == IDLE || sym_end) sym_cnt <= '0;
      else                          sym_cnt <= sym_cnt + SYM_ONE;
      if (pop)                          bit_idx <= '0;
      else if (state == DATA && sym_end) bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 10 clocks per symbol.
module tb_uart_transmitter;

  localparam int CF = 1000;
  localparam int BR = 100;
  localparam int D  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;
  logic [2:0] fifo_count;

  uart_transmitter #(
    .CLOCK_FREQ(CF),
    .BAUD_RATE (BR),
    .FIFO_DEPTH(D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       out;
    logic       ready;
    logic       busy;
    logic [2:0] count;
  } vec_t;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int acc_n = 0;
  int last_acc = -1;
  int q_from = 0;
  bit use_q = 1'b0;
  byte unsigned txq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit acc;
    acc = 1'b0;
    if (use_q) begin
      if (txq.size() > 0 && cyc + 1 >= q_from) begin
        data_in_valid = 1'b1;
        data_in       = txq[0];
        acc           = data_in_ready;
      end else begin
        data_in_valid = 1'b0;
      end
    end
    @(posedge clk);
    if (acc) begin
      void'(txq.pop_front());
      acc_n++;
      last_acc = cyc + 1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_low(input int lim, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i <= lim && !ok; i++) begin
      if (serial_out === 1'b0) begin
        ok = 1'b1;
        at = cyc;
      end else if (i < lim) begin
        step();
      end
    end
  endtask

  // Enters "off" cycles into the start bit, exits on the last stop cycle.
  task automatic rx_body(input string nm, input logic [7:0] exp,
                         input int off);
    logic [7:0] b;
    b = '0;
    repeat (4 - off) step();
    chk({nm, " start"}, 32'(serial_out), 32'(0));
    for (int i = 0; i < 8; i++) begin
      repeat (10) step();
      b[i] = serial_out;
    end
    repeat (10) step();
    chk({nm, " stop"}, 32'(serial_out), 32'(1));
    repeat (5) step();
    chk({nm, " byte"}, 32'(b), 32'(exp));
  endtask

  task automatic rx_frame(input string nm, input logic [7:0] exp,
                          input int lim, output int at);
    bit ok;
    wait_low(lim, at, ok);
    chk({nm, " found"}, 32'(ok), 32'(1));
    if (ok) rx_body(nm, exp, 0);
  endtask

  function automatic vec_t mk(input logic r, input logic v,
                              input logic [7:0] d, input logic o,
                              input logic rd, input logic bz,
                              input logic [2:0] c);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d;
    t.out = o; t.ready = rd; t.busy = bz; t.count = c;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int n;
    int e0;
    int b;
    int at;
    int bad;
    logic [7:0] rb;

    for (int i = 0; i < 5; i++)
      tbl[i] = mk(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 3'd0);
    tbl[5] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0);
    tbl[6] = mk(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 3'd1);
    tbl[7] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0);
    tbl[8] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0);

    rst = 1'b1;
    data_in_valid = 1'b0;
    data_in = 8'h00;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst;
      data_in_valid = tbl[i].valid;
      data_in = tbl[i].data;
      step();
      chk($sformatf("vec%0d out", i), 32'(serial_out), 32'(tbl[i].out));
      chk($sformatf("vec%0d ready", i), 32'(data_in_ready),
          32'(tbl[i].ready));
      chk($sformatf("vec%0d busy", i), 32'(tx_busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d count", i), 32'(fifo_count),
          32'(tbl[i].count));
    end

    // A5 accepted at N; here at N+2
    n = cyc - 2;
    repeat (9) step();
    chk("a5 last start", 32'(serial_out), 32'(0));
    step();
    chk("a5 bit0 first", 32'(serial_out), 32'(1));
    rb = '0;
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat (10) step();
      rb[i] = serial_out;
    end
    chk("a5 byte", 32'(rb), 32'(8'hA5));
    repeat (10) step();
    chk("a5 stop", 32'(serial_out), 32'(1));
    repeat (n + 100 - cyc) step();
    chk("a5 busy end", 32'(tx_busy), 32'(1));
    repeat (2) step();
    chk("a5 busy low", 32'(tx_busy), 32'(0));
    chk("a5 idle line", 32'(serial_out), 32'(1));

    // Burst with backpressure
    b = acc_n;
    txq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    use_q = 1'b1;
    for (int i = 0; i < 10 && acc_n == b; i++) step();
    n = cyc;
    e0 = n + 2;
    repeat (4) step();
    chk("burst accepted", 32'(acc_n - b), 32'(5));
    chk("burst full count", 32'(fifo_count), 32'(4));
    chk("burst ready low", 32'(data_in_ready), 32'(0));
    rx_body("burst1", 8'h01, 2);
    chk("burst ready back", 32'(data_in_ready), 32'(1));
    chk("burst count3", 32'(fifo_count), 32'(3));
    for (int k = 2; k <= 6; k++) begin
      rx_frame($sformatf("burst%0d", k), 8'(k), 2, at);
      chk($sformatf("burst%0d gap", k), 32'(at), 32'(e0 + 100 * (k - 1)));
    end
    chk("burst total", 32'(acc_n - b), 32'(6));
    repeat (2) step();
    chk("burst busy low", 32'(tx_busy), 32'(0));

    // Push on the same edge as a STOP->START pop
    b = acc_n;
    txq = {8'hC3, 8'h3C, 8'h7E};
    for (int i = 0; i < 10 && acc_n == b; i++) step();
    n = cyc;
    e0 = n + 2;
    repeat (2) step();
    chk("pp accepted", 32'(acc_n - b), 32'(3));
    chk("pp count2", 32'(fifo_count), 32'(2));
    q_from = n + 101;
    txq.push_back(8'h81);
    rx_body("pp0", 8'hC3, 0);
    chk("pp count held", 32'(fifo_count), 32'(2));
    chk("pp push edge", 32'(last_acc), 32'(n + 101));
    q_from = 0;
    rx_frame("pp1", 8'h3C, 2, at);
    chk("pp1 gap", 32'(at), 32'(e0 + 100));
    rx_frame("pp2", 8'h7E, 2, at);
    rx_frame("pp3", 8'h81, 2, at);
    chk("pp3 gap", 32'(at), 32'(e0 + 300));

    // Reset during bit 3 with three bytes queued
    repeat (3) step();
    b = acc_n;
    txq = {8'h30, 8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 10 && acc_n == b; i++) step();
    n = cyc;
    e0 = n + 2;
    repeat (e0 + 43 - cyc) step();
    chk("mid bit3 low", 32'(serial_out), 32'(0));
    chk("mid queued", 32'(fifo_count), 32'(3));
    use_q = 1'b0;
    data_in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("mid rst out", 32'(serial_out), 32'(1));
    chk("mid rst count", 32'(fifo_count), 32'(0));
    chk("mid rst ready", 32'(data_in_ready), 32'(1));
    chk("mid rst busy", 32'(tx_busy), 32'(0));
    rst = 1'b0;
    bad = 0;
    repeat (150) begin
      step();
      if (serial_out !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("mid quiet", 32'(bad), 32'(0));
    txq = {8'hFF};
    use_q = 1'b1;
    rx_frame("ff", 8'hFF, 10, at);
    bad = 0;
    repeat (120) begin
      step();
      if (serial_out !== 1'b1) bad++;
    end
    chk("ff no extra", 32'(bad), 32'(0));

    // Interleaved bursts wrap the pointers twice
    txq = {8'h00, 8'h01, 8'h02};
    for (int i = 0; i < 10; i++) begin
      rx_frame($sformatf("wrap%0d", i), 8'(i), 300, at);
      if (i == 1) txq = {8'h03, 8'h04, 8'h05, 8'h06};
      if (i == 4) txq = {8'h07, 8'h08, 8'h09};
    end
    use_q = 1'b0;
    data_in_valid = 1'b0;
    repeat (3) step();
    chk("wrap drained", 32'(tx_busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
